// File: rtl/lsq_pkg.sv
// Shared types for the parametrised load/store queue: slot states, the
// slot record and the slot-ID width helper.
package lsq_pkg;

  // Default field widths of a queue slot.
  localparam int LSQ_ADDR_W  = 32;
  localparam int LSQ_DATA_W  = 32;
  localparam int LSQ_CNTRL_W = 16;
  localparam int LSQ_Z_W     = 4;

  // Lifecycle of one slot. FREE must encode as zero so a cleared slot is FREE.
  typedef enum logic [1:0] {
    SLOT_FREE   = 2'b00,
    SLOT_WAIT   = 2'b01,
    SLOT_ISSUED = 2'b10,
    SLOT_DONE   = 2'b11
  } slot_state_e;

  typedef struct packed {
    slot_state_e              state;
    logic                     rw;
    logic [LSQ_ADDR_W-1:0]    addr;
    logic [LSQ_DATA_W-1:0]    data;
    logic [LSQ_CNTRL_W-1:0]   cntrl;
    logic [LSQ_Z_W-1:0]       z;
  } lsq_slot_t;

  // Slot-ID width; at least one bit even for the smallest queue.
  function automatic int idx_w(input int depth);
    if (depth <= 2) begin
      return 1;
    end else begin
      return $clog2(depth);
    end
  endfunction

endpackage

// File: rtl/lsq_fwd_match.sv
// Store-to-load forwarding lookup: finds the youngest store still in the
// queue whose address equals the incoming load address. Only instantiated
// by lsq_param_queue when LSQ_FWD_EN is defined.
module lsq_fwd_match
  import lsq_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int IDX_W = idx_w(DEPTH)
) (
  input  lsq_slot_t              slots_i [DEPTH],
  input  logic [IDX_W-1:0]       head_i,
  input  logic [IDX_W-1:0]       tail_i,
  input  logic [LSQ_ADDR_W-1:0]  addr_i,
  output logic                   hit_o,
  output logic [LSQ_DATA_W-1:0]  data_o
);

  // Occupied span from head to tail; zero means empty or completely full,
  // in which case the FREE check alone decides occupancy.
  logic [IDX_W-1:0]      span_s;
  logic [DEPTH-1:0]      cand_s;
  logic [LSQ_DATA_W-1:0] cand_data_s [DEPTH];

  assign span_s = tail_i - head_i;

  // Candidate g is the slot of age g+1 counted back from tail (g=0 youngest).
  for (genvar g = 0; g < DEPTH; g++) begin : g_age
    logic [IDX_W-1:0] idx_s;
    logic             in_range_s;
    logic             unused_sideband_s;

    assign idx_s      = tail_i - IDX_W'(g + 1);
    assign in_range_s = (span_s == {IDX_W{1'b0}}) ||
                        ((IDX_W+1)'(g + 1) <= {1'b0, span_s});
    assign cand_s[g]  = in_range_s &&
                        (slots_i[idx_s].state != SLOT_FREE) &&
                        slots_i[idx_s].rw &&
                        (slots_i[idx_s].addr == addr_i);
    assign cand_data_s[g] = slots_i[idx_s].data;
    assign unused_sideband_s = ^{slots_i[g].cntrl, slots_i[g].z};
  end

  // Walk from oldest to youngest so the youngest matching store wins.
  always_comb begin
    hit_o  = |cand_s;
    data_o = {LSQ_DATA_W{1'b0}};
    for (int g = DEPTH - 1; g >= 0; g--) begin
      data_o = cand_s[g] ? cand_data_s[g] : data_o;
    end
  end

endmodule

// File: rtl/lsq_param_queue.sv
// Parametrised load/store queue between the MEM stage and the data cache.
// Requests are allocated in program order, issued to memory in order,
// completed by slot ID in any order and retired to the core in order.
// Optional feature macro: LSQ_FWD_EN (store-to-load forwarding; loads that
// hit an older queued store complete at allocation and skip memory).
module lsq_param_queue
  import lsq_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = LSQ_ADDR_W,
  parameter int DATA_W  = LSQ_DATA_W,
  parameter int CNTRL_W = LSQ_CNTRL_W,
  parameter int Z_W     = LSQ_Z_W,
  localparam int IDX_W  = idx_w(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic               req_rw,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [DATA_W-1:0]  req_data,
  input  logic [CNTRL_W-1:0] req_cntrl,
  input  logic [Z_W-1:0]     req_z,
  output logic               stall_out,
  output logic               cpl_valid,
  output logic               cpl_rw,
  output logic [ADDR_W-1:0]  cpl_addr,
  output logic [DATA_W-1:0]  cpl_data,
  output logic [CNTRL_W-1:0] cpl_cntrl,
  output logic [Z_W-1:0]     cpl_z,
  output logic               mem_valid,
  output logic               mem_rw,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic [IDX_W-1:0]   mem_id,
  input  logic               mem_stall,
  input  logic               mem_ready,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic [IDX_W-1:0]   mem_id_in
);

  // Slot fields are sized by the package widths; keep ADDR_W/DATA_W/CNTRL_W/Z_W
  // equal to the package constants (widen both together).
  localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W:0]   CNT_ONE  = {{IDX_W{1'b0}}, 1'b1};
  localparam logic [IDX_W:0]   CNT_FULL = (IDX_W+1)'(DEPTH);

  lsq_slot_t          slot_q [DEPTH];
  lsq_slot_t          slot_d [DEPTH];
  logic [IDX_W-1:0]   head_q,  head_d;
  logic [IDX_W-1:0]   issue_q, issue_d;
  logic [IDX_W-1:0]   tail_q,  tail_d;
  logic [IDX_W:0]     count_q, count_d;

  logic               cpl_valid_q, cpl_valid_d;
  logic               cpl_rw_q,    cpl_rw_d;
  logic [ADDR_W-1:0]  cpl_addr_q,  cpl_addr_d;
  logic [DATA_W-1:0]  cpl_data_q,  cpl_data_d;
  logic [CNTRL_W-1:0] cpl_cntrl_q, cpl_cntrl_d;
  logic [Z_W-1:0]     cpl_z_q,     cpl_z_d;

  lsq_slot_t              issue_slot_s;
  lsq_slot_t              head_slot_s;
  logic                   stall_s;
  logic                   alloc_s;
  logic                   mem_valid_s;
  logic                   issue_go_s;
  logic                   retire_s;
  logic                   skip_s;
  logic                   fwd_load_s;
  logic [LSQ_DATA_W-1:0]  alloc_data_s;

  assign issue_slot_s = slot_q[issue_q];
  assign head_slot_s  = slot_q[head_q];
  assign stall_s      = (count_q == CNT_FULL);
  assign alloc_s      = req_valid && !stall_s;
  assign mem_valid_s  = (issue_slot_s.state == SLOT_WAIT);
  assign issue_go_s   = mem_valid_s && !mem_stall;
  assign retire_s     = (head_slot_s.state == SLOT_DONE);

`ifdef LSQ_FWD_EN
  logic                  fwd_hit_s;
  logic [LSQ_DATA_W-1:0] fwd_data_s;

  lsq_fwd_match #(.DEPTH(DEPTH)) u_fwd_match (
    .slots_i (slot_q),
    .head_i  (head_q),
    .tail_i  (tail_q),
    .addr_i  (LSQ_ADDR_W'(req_addr)),
    .hit_o   (fwd_hit_s),
    .data_o  (fwd_data_s)
  );

  assign fwd_load_s   = !req_rw && fwd_hit_s;
  assign alloc_data_s = fwd_load_s ? fwd_data_s : LSQ_DATA_W'(req_data);
  // A forwarded load sits DONE under the issue pointer and is stepped over.
  assign skip_s       = (issue_slot_s.state == SLOT_DONE);
`else
  assign fwd_load_s   = 1'b0;
  assign alloc_data_s = LSQ_DATA_W'(req_data);
  assign skip_s       = 1'b0;
`endif

  // Per-slot state transitions; each state has exactly one way out.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_d[i] = slot_q[i];
      case (slot_q[i].state)
        SLOT_FREE: begin
          if (alloc_s && (tail_q == IDX_W'(i))) begin
            slot_d[i].state = fwd_load_s ? SLOT_DONE : SLOT_WAIT;
            slot_d[i].rw    = req_rw;
            slot_d[i].addr  = LSQ_ADDR_W'(req_addr);
            slot_d[i].data  = alloc_data_s;
            slot_d[i].cntrl = LSQ_CNTRL_W'(req_cntrl);
            slot_d[i].z     = LSQ_Z_W'(req_z);
          end else begin
            slot_d[i] = slot_q[i];
          end
        end
        SLOT_WAIT: begin
          if (issue_go_s && (issue_q == IDX_W'(i))) begin
            slot_d[i].state = SLOT_ISSUED;
          end else begin
            slot_d[i] = slot_q[i];
          end
        end
        SLOT_ISSUED: begin
          if (mem_ready && (mem_id_in == IDX_W'(i))) begin
            slot_d[i].state = SLOT_DONE;
            slot_d[i].data  = slot_q[i].rw ? slot_q[i].data : LSQ_DATA_W'(mem_rdata);
          end else begin
            slot_d[i] = slot_q[i];
          end
        end
        SLOT_DONE: begin
          if (retire_s && (head_q == IDX_W'(i))) begin
            slot_d[i].state = SLOT_FREE;
          end else begin
            slot_d[i] = slot_q[i];
          end
        end
        default: begin
          slot_d[i] = slot_q[i];
        end
      endcase
    end
  end

  // Pointer and occupancy bookkeeping.
  always_comb begin
    if (alloc_s) begin
      tail_d = tail_q + IDX_ONE;
    end else begin
      tail_d = tail_q;
    end

    if (issue_go_s || skip_s) begin
      issue_d = issue_q + IDX_ONE;
    end else begin
      issue_d = issue_q;
    end

    if (retire_s) begin
      head_d = head_q + IDX_ONE;
    end else begin
      head_d = head_q;
    end

    case ({alloc_s, retire_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Retire payload for the registered completion port; zero when idle.
  always_comb begin
    if (retire_s) begin
      cpl_valid_d = 1'b1;
      cpl_rw_d    = head_slot_s.rw;
      cpl_addr_d  = ADDR_W'(head_slot_s.addr);
      cpl_data_d  = DATA_W'(head_slot_s.data);
      cpl_cntrl_d = CNTRL_W'(head_slot_s.cntrl);
      cpl_z_d     = Z_W'(head_slot_s.z);
    end else begin
      cpl_valid_d = 1'b0;
      cpl_rw_d    = 1'b0;
      cpl_addr_d  = {ADDR_W{1'b0}};
      cpl_data_d  = {DATA_W{1'b0}};
      cpl_cntrl_d = {CNTRL_W{1'b0}};
      cpl_z_d     = {Z_W{1'b0}};
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= '0;
      end
      head_q      <= {IDX_W{1'b0}};
      issue_q     <= {IDX_W{1'b0}};
      tail_q      <= {IDX_W{1'b0}};
      count_q     <= {(IDX_W+1){1'b0}};
      cpl_valid_q <= 1'b0;
      cpl_rw_q    <= 1'b0;
      cpl_addr_q  <= {ADDR_W{1'b0}};
      cpl_data_q  <= {DATA_W{1'b0}};
      cpl_cntrl_q <= {CNTRL_W{1'b0}};
      cpl_z_q     <= {Z_W{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= slot_d[i];
      end
      head_q      <= head_d;
      issue_q     <= issue_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      cpl_valid_q <= cpl_valid_d;
      cpl_rw_q    <= cpl_rw_d;
      cpl_addr_q  <= cpl_addr_d;
      cpl_data_q  <= cpl_data_d;
      cpl_cntrl_q <= cpl_cntrl_d;
      cpl_z_q     <= cpl_z_d;
    end
  end

  assign stall_out = stall_s;
  assign cpl_valid = cpl_valid_q;
  assign cpl_rw    = cpl_rw_q;
  assign cpl_addr  = cpl_addr_q;
  assign cpl_data  = cpl_data_q;
  assign cpl_cntrl = cpl_cntrl_q;
  assign cpl_z     = cpl_z_q;

  // Memory request comes straight from the slot under the issue pointer and
  // is forced to zero whenever nothing is being requested.
  assign mem_valid = mem_valid_s;
  assign mem_rw    = mem_valid_s & issue_slot_s.rw;
  assign mem_addr  = mem_valid_s ? ADDR_W'(issue_slot_s.addr) : {ADDR_W{1'b0}};
  assign mem_wdata = mem_valid_s ? DATA_W'(issue_slot_s.data) : {DATA_W{1'b0}};
  assign mem_id    = mem_valid_s ? issue_q : {IDX_W{1'b0}};

endmodule

// File: tb/tb_lsq_param_queue.sv
// Randomised self-checking bench for lsq_param_queue (DEPTH=4). The reference
// is program-order: each load's result is the memory value after all older
// stores, retirement order equals allocation order, and occupancy is the
// number of allocations minus retirements.
module tb_lsq_param_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_rw;
  logic [31:0] req_addr, req_data;
  logic [15:0] req_cntrl;
  logic [3:0]  req_z;
  logic        stall_out;
  logic        cpl_valid, cpl_rw;
  logic [31:0] cpl_addr, cpl_data;
  logic [15:0] cpl_cntrl;
  logic [3:0]  cpl_z;
  logic        mem_valid, mem_rw;
  logic [31:0] mem_addr, mem_wdata;
  logic [1:0]  mem_id;
  logic        mem_stall, mem_ready;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_id_in;

  always #5 clk = ~clk;

  lsq_param_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr),
    .req_data(req_data), .req_cntrl(req_cntrl), .req_z(req_z),
    .stall_out(stall_out),
    .cpl_valid(cpl_valid), .cpl_rw(cpl_rw), .cpl_addr(cpl_addr),
    .cpl_data(cpl_data), .cpl_cntrl(cpl_cntrl), .cpl_z(cpl_z),
    .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_id(mem_id),
    .mem_stall(mem_stall), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .mem_id_in(mem_id_in)
  );

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
    logic [15:0] cntrl;
    logic [3:0]  z;
    logic [1:0]  id;
  } ent_t;

  typedef struct {
    logic [1:0]  id;
    logic        rw;
    logic [31:0] data;
  } rsp_t;

  ent_t exp_q[$];     // entries awaiting retirement, program order
  ent_t memreq_q[$];  // entries expected on the memory port, in order
  ent_t script_q[$];  // directed requests fed before random ones
  rsp_t pend_q[$];    // requests accepted by memory, not yet completed

  logic [31:0] mem_arr [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  int n_checks = 0;
  int n_pass = 0;
  int model_count = 0;
  int alloc_cnt = 0;
  int stall_left = 0;
  bit pending_alloc = 1'b0;
  bit have_req = 1'b0;
  bit hold_chk = 1'b0;
  ent_t cur_req;
  logic        hold_rw;
  logic [31:0] hold_addr, hold_wdata;
  logic [1:0]  hold_id;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    else return a ^ 32'h5a5a_0000;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    else return a ^ 32'h5a5a_0000;
  endfunction

  function automatic ent_t mk(input logic rw, input logic [31:0] a, input logic [31:0] d);
    ent_t e;
    e.rw = rw; e.addr = a; e.data = d;
    e.cntrl = 16'($urandom); e.z = 4'($urandom); e.id = 2'd0;
    return e;
  endfunction

  // One clock of bench activity, performed at the falling edge.
  task automatic step_cycle(input bit gen_req, input bit lifo);
    ent_t e;
    rsp_t r;
    int k;
    bit fwd;
    bit in_pend;
    logic [1:0] bid;
    @(negedge clk);

    // Retirement side and occupancy.
    model_count = model_count + int'(pending_alloc) - int'(cpl_valid);
    pending_alloc = 1'b0;
    if (exp_q.size() == 0) begin
      check_eq("cpl_spurious", cpl_valid, 1'b0);
    end else if (cpl_valid) begin
      e = exp_q.pop_front();
      check_eq("cpl_rw", cpl_rw, e.rw);
      check_eq("cpl_addr", cpl_addr, e.addr);
      check_eq("cpl_data", cpl_data, e.data);
      check_eq("cpl_cntrl", cpl_cntrl, e.cntrl);
      check_eq("cpl_z", cpl_z, e.z);
    end
    check_eq("stall_out", stall_out, (model_count == DEPTH));

    // A request held off by mem_stall must be presented unchanged.
    if (hold_chk) begin
      check_eq("hold_valid", mem_valid, 1'b1);
      check_eq("hold_rw", mem_rw, hold_rw);
      check_eq("hold_addr", mem_addr, hold_addr);
      check_eq("hold_wdata", mem_wdata, hold_wdata);
      check_eq("hold_id", mem_id, hold_id);
    end
    hold_chk = 1'b0;

    // Memory completions, possibly out of order, plus stray ones.
    mem_ready = 1'b0; mem_id_in = 2'd0; mem_rdata = 32'd0;
    if (pend_q.size() > 0 && $urandom_range(0, 2) != 0) begin
      k = lifo ? pend_q.size() - 1 : int'($urandom_range(0, pend_q.size() - 1));
      r = pend_q[k];
      pend_q.delete(k);
      mem_ready = 1'b1; mem_id_in = r.id;
      mem_rdata = r.rw ? $urandom : r.data;
    end else if ($urandom_range(0, 3) == 0) begin
      bid = 2'($urandom);
      in_pend = 1'b0;
      foreach (pend_q[j]) if (pend_q[j].id == bid) in_pend = 1'b1;
      if (!in_pend) begin
        mem_ready = 1'b1; mem_id_in = bid; mem_rdata = $urandom;
      end
    end

    // Memory request acceptance with occasional 1..3 cycle stalls.
    if (stall_left > 0) begin
      mem_stall = 1'b1; stall_left--;
    end else if ($urandom_range(0, 7) == 0) begin
      mem_stall = 1'b1; stall_left = $urandom_range(0, 2);
    end else begin
      mem_stall = 1'b0;
    end
    if (memreq_q.size() == 0) begin
      check_eq("mem_spurious", mem_valid, 1'b0);
    end else if (mem_valid) begin
      if (mem_stall) begin
        hold_chk = 1'b1;
        hold_rw = mem_rw; hold_addr = mem_addr; hold_wdata = mem_wdata; hold_id = mem_id;
      end else begin
        e = memreq_q.pop_front();
        check_eq("mem_rw", mem_rw, e.rw);
        check_eq("mem_addr", mem_addr, e.addr);
        check_eq("mem_id", mem_id, e.id);
        r.id = e.id; r.rw = e.rw;
        if (e.rw) begin
          check_eq("mem_wdata", mem_wdata, e.data);
          mem_arr[e.addr] = e.data;
          r.data = 32'd0;
        end else begin
          r.data = mem_rd(e.addr);
        end
        pend_q.push_back(r);
      end
    end

    // Core requests; a refused request is held until accepted.
    req_valid = 1'b0;
    if (!have_req && gen_req) begin
      if (script_q.size() > 0) begin
        cur_req = script_q.pop_front(); have_req = 1'b1;
      end else if ($urandom_range(0, 3) != 0) begin
        cur_req = mk(1'($urandom), 32'd40 + 32'(4 * $urandom_range(0, 3)), $urandom);
        have_req = 1'b1;
      end
    end
    if (have_req) begin
      req_valid = 1'b1; req_rw = cur_req.rw; req_addr = cur_req.addr;
      req_data = cur_req.data; req_cntrl = cur_req.cntrl; req_z = cur_req.z;
      if (!stall_out) begin
        e = cur_req;
        e.id = alloc_cnt[1:0];
        alloc_cnt++;
        fwd = 1'b0;
`ifdef LSQ_FWD_EN
        if (!e.rw) foreach (exp_q[j]) if (exp_q[j].rw && exp_q[j].addr == e.addr) fwd = 1'b1;
`endif
        if (e.rw) ref_mem[e.addr] = e.data;
        else e.data = ref_rd(e.addr);
        exp_q.push_back(e);
        if (!fwd) memreq_q.push_back(e);
        pending_alloc = 1'b1;
        have_req = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0; mem_ready = 1'b0; mem_stall = 1'b0;
    @(negedge clk);
    exp_q.delete(); memreq_q.delete();
    model_count = 0; pending_alloc = 1'b0; have_req = 1'b0; hold_chk = 1'b0;
    stall_left = 0; alloc_cnt = 0;
    ref_mem = mem_arr;
    check_eq("rst_cpl_valid", cpl_valid, 1'b0);
    check_eq("rst_cpl_data", cpl_data, 32'd0);
    check_eq("rst_stall_out", stall_out, 1'b0);
    check_eq("rst_mem_valid", mem_valid, 1'b0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_rw = 1'b0; req_addr = 32'd0; req_data = 32'd0;
    req_cntrl = 16'd0; req_z = 4'd0; mem_stall = 1'b0; mem_ready = 1'b0;
    mem_rdata = 32'd0; mem_id_in = 2'd0;
    repeat (2) @(negedge clk);
    do_reset();

    // Directed: stores then loads to the same words, forwarding pair,
    // then a burst that fills the queue.
    script_q.push_back(mk(1'b1, 32'd40, 32'd9000));
    script_q.push_back(mk(1'b1, 32'd44, 32'd9001));
    script_q.push_back(mk(1'b0, 32'd40, 32'd0));
    script_q.push_back(mk(1'b0, 32'd44, 32'd0));
    script_q.push_back(mk(1'b1, 32'd40, 32'd7));
    script_q.push_back(mk(1'b0, 32'd40, 32'd0));
    for (int i = 0; i < 5; i++) script_q.push_back(mk(1'b0, 32'd48, 32'd0));
    repeat (80) step_cycle(1'b1, 1'b1);

    repeat (600) step_cycle(1'b1, 1'b0);

    // Reset with requests outstanding at memory; their late completions
    // must be dropped.
    for (int i = 0; i < 200 && pend_q.size() < 2; i++) step_cycle(1'b1, 1'b0);
    check_eq("pre_reset_outstanding", pend_q.size() >= 2, 1'b1);
    do_reset();
    for (int i = 0; i < 60 && pend_q.size() > 0; i++) step_cycle(1'b0, 1'b0);
    pend_q.delete();

    repeat (600) step_cycle(1'b1, 1'b0);

    for (int i = 0; i < 300 && (exp_q.size() > 0 || have_req); i++) step_cycle(1'b0, 1'b0);
    check_eq("drain_left", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
